// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier library: FSM state encodings,
// accumulator width derivation and count saturation constant.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } mac_state_e;

  // Accumulator width: full product width plus guard bits.
  function automatic int acc_width(input int sw, input int gw);
    return 2 * sw + gw;
  endfunction

  // Beat count saturates at all-ones of a gw-bit counter.
  function automatic int cnt_sat_value(input int gw);
    return (2 ** gw) - 1;
  endfunction

endpackage

// File: rtl/cmult.sv
// Combinational unsigned multiplier from the multiplier library.
// Produces the full 2*SW-bit product of two SW-bit operands.
module cmult #(
  parameter int SW = 24
) (
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic [2*SW-1:0] Data_S_o
);

  // Full-width product; operands are zero-extended so no bits are lost.
  always_comb begin
    Data_S_o = {{SW{1'b0}}, Data_A_i} * {{SW{1'b0}}, Data_B_i};
  end

endmodule

// File: rtl/cmult_mac.sv
// Multiply-accumulate stage around cmult. Operand beats arrive on a
// valid/ready stream; products are registered (stage P), then summed per
// group (stage A) until a beat flagged last. The group sum, beat count and
// overflow flag are held on a valid/ready output until consumed.
// Optional build macro: CMULT_MAC_SAT_EN -- saturate the accumulator at
// all-ones on overflow instead of wrapping modulo 2^ACC_W.
module cmult_mac
  import mult_pkg::*;
#(
  parameter  int SW    = 24,
  parameter  int GW    = 8,
  localparam int ACC_W = acc_width(SW, GW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW-1:0]    Data_A_i,
  input  logic [SW-1:0]    Data_B_i,
  input  logic             valid_i,
  input  logic             last_i,
  output logic             ready_o,
  output logic [ACC_W-1:0] Data_S_o,
  output logic [GW-1:0]    cnt_o,
  output logic             ovf_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam logic [GW-1:0] CNT_MAX = GW'(cnt_sat_value(GW));

  mac_state_e        state;
  logic              accept;
  logic [2*SW-1:0]   prod;
  logic [2*SW-1:0]   p_prod;
  logic              p_valid;
  logic              p_last;
  logic              first;
  logic [ACC_W-1:0]  acc;
  logic [GW-1:0]     cnt;
  logic              ovf;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]  acc_next;
  logic [GW-1:0]     cnt_next;
  logic              ovf_next;

  cmult #(.SW(SW)) u_cmult (
    .Data_A_i (Data_A_i),
    .Data_B_i (Data_B_i),
    .Data_S_o (prod)
  );

  // Stall new beats while a result is held or while the last beat of the
  // current group is still in stage P.
  assign ready_o = (state != S_HOLD) && !(p_valid && p_last);
  assign accept  = valid_i && ready_o;

  // Stage P: register the product and its beat qualifiers.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all stages
    // update from the same pre-edge values; blocking would let stage A see
    // this cycle's new product a cycle early.
    if (!rst_n) begin
      p_prod  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= accept;
      p_last  <= accept && last_i;
      if (accept) p_prod <= prod;
    end
  end

  // Stage A next-value logic: restart from zero on the first beat of a
  // group, detect carry out of the accumulator, saturate the beat count.
  always_comb begin
    // NOTE: each signal gets a default before any branch so no path leaves
    // it unassigned, which would infer a latch.
    acc_base = first ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - 2*SW){1'b0}}, p_prod};
    ovf_next = (first ? 1'b0 : ovf) | acc_sum[ACC_W];
`ifdef CMULT_MAC_SAT_EN
    acc_next = ovf_next ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
    acc_next = acc_sum[ACC_W-1:0];
`endif
    if (first)               cnt_next = GW'(1);
    else if (cnt == CNT_MAX) cnt_next = cnt;
    else                     cnt_next = cnt + GW'(1);
  end

  // Stage A: accumulate each registered product into the group state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (p_valid) begin
      acc <= acc_next;
      cnt <= cnt_next;
      ovf <= ovf_next;
    end
  end

  // Group control FSM: tracks open group, presents result, and re-arms the
  // first-beat flag once the result has been taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      valid_o <= 1'b0;
      first   <= 1'b1;
    end else begin
      if (p_valid) first <= 1'b0;
      case (state)
        S_IDLE: begin
          if (p_valid && p_last) begin
            state   <= S_HOLD;
            valid_o <= 1'b1;
          end else if (accept && !last_i) begin
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (p_valid && p_last) begin
            state   <= S_HOLD;
            valid_o <= 1'b1;
          end
        end
        S_HOLD: begin
          if (ready_i) begin
            state   <= S_IDLE;
            valid_o <= 1'b0;
            first   <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign Data_S_o = acc;
  assign cnt_o    = cnt;
  assign ovf_o    = ovf;

endmodule

// File: tb/tb_cmult_mac.sv
// Scoreboard bench for cmult_mac: directed groups push their expected result
// into a queue; per-instance monitors pop and compare on each handshake.
// A second instance (SW=4, GW=1) exercises accumulator overflow.
module tb_cmult_mac;

  typedef struct {
    logic [63:0] sum;
    logic [63:0] cnt;
    logic [63:0] ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [23:0] a0 = '0, b0 = '0;
  logic        valid0 = 1'b0, last0 = 1'b0, rdy_in0 = 1'b0;
  logic        ready0, vout0, ovf0;
  logic [55:0] sum0;
  logic [7:0]  cnt0;

  logic [3:0]  a1 = '0, b1 = '0;
  logic        valid1 = 1'b0, last1 = 1'b0, rdy_in1 = 1'b0;
  logic        ready1, vout1, ovf1;
  logic [8:0]  sum1;
  logic [0:0]  cnt1;

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  cmult_mac #(.SW(24), .GW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .Data_A_i(a0), .Data_B_i(b0),
    .valid_i(valid0), .last_i(last0), .ready_o(ready0),
    .Data_S_o(sum0), .cnt_o(cnt0), .ovf_o(ovf0),
    .valid_o(vout0), .ready_i(rdy_in0)
  );

  cmult_mac #(.SW(4), .GW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Data_A_i(a1), .Data_B_i(b1),
    .valid_i(valid1), .last_i(last1), .ready_o(ready1),
    .Data_S_o(sum1), .cnt_o(cnt1), .ovf_o(ovf1),
    .valid_o(vout1), .ready_i(rdy_in1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] s, input logic [63:0] c, input logic [63:0] o);
    exp_t e;
    e.sum = s; e.cnt = c; e.ovf = o;
    return e;
  endfunction

  // Monitor for dut0: compare the held result at each output handshake.
  always @(negedge clk) begin
    if (rst_n && vout0 && rdy_in0) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0_sum", 64'(sum0), e.sum);
        check("dut0_cnt", 64'(cnt0), e.cnt);
        check("dut0_ovf", 64'(ovf0), e.ovf);
      end
    end
  end

  // Monitor for dut1.
  always @(negedge clk) begin
    if (rst_n && vout1 && rdy_in1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1_sum", 64'(sum1), e.sum);
        check("dut1_cnt", 64'(cnt1), e.cnt);
        check("dut1_ovf", 64'(ovf1), e.ovf);
      end
    end
  end

  // Present one beat to dut0 and hold it until accepted; called #1 after an edge.
  task automatic send0(input logic [23:0] a, input logic [23:0] b, input bit last);
    int  n = 0;
    bit  took = 1'b0;
    a0 = a; b0 = b; valid0 = 1'b1; last0 = last;
    do begin
      took = ready0;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 200);
    if (!took) check("send0_timeout", 64'd0, 64'd1);
    stalls += n - 1;
    valid0 = 1'b0; last0 = 1'b0;
  endtask

  task automatic send1(input logic [3:0] a, input logic [3:0] b, input bit last);
    int  n = 0;
    bit  took = 1'b0;
    a1 = a; b1 = b; valid1 = 1'b1; last1 = last;
    do begin
      took = ready1;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 200);
    if (!took) check("send1_timeout", 64'd0, 64'd1);
    valid1 = 1'b0; last1 = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (!(vout0 == 1'b0 && ready0 == 1'b1) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("dut0_idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (!(vout1 == 1'b0 && ready1 == 1'b1) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("dut1_idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    // Reset and reset-state checks.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready0), 64'd1);
    check("rst_valid", 64'(vout0), 64'd0);
    check("rst_sum",   64'(sum0), 64'd0);
    check("rst_cnt",   64'(cnt0), 64'd0);
    check("rst_ovf",   64'(ovf0), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic three-beat group: 12+30+56 = 98? no: 3*4+5*6+7*8 = 12+30+56 = 98.
    rdy_in0 = 1'b1;
    q0.push_back(mk(64'd98, 64'd3, 64'd0));
    send0(24'd3, 24'd4, 1'b0);
    send0(24'd5, 24'd6, 1'b0);
    send0(24'd7, 24'd8, 1'b1);
    check("lat_valid_before", 64'(vout0), 64'd0);
    check("lat_ready_low",    64'(ready0), 64'd0);
    @(posedge clk); #1;
    check("lat_valid_after",  64'(vout0), 64'd1);
    wait_idle0();

    // Full-scale single beat held for 10 cycles while a new beat waits.
    rdy_in0 = 1'b0;
    q0.push_back(mk(64'hFFFFFE000001, 64'd1, 64'd0));
    send0(24'hFFFFFF, 24'hFFFFFF, 1'b1);
    check("single_ready_low", 64'(ready0), 64'd0);
    a0 = 24'd9; b0 = 24'd9; valid0 = 1'b1; last0 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 64'(vout0), 64'd1);
      check("hold_sum",   64'(sum0), 64'hFFFFFE000001);
      check("hold_cnt",   64'(cnt0), 64'd1);
      check("hold_ready", 64'(ready0), 64'd0);
      @(posedge clk); #1;
    end
    q0.push_back(mk(64'd81, 64'd1, 64'd0));
    rdy_in0 = 1'b1;
    stalls = 0;
    send0(24'd9, 24'd9, 1'b1);
    check("release_accept_gap", 64'(stalls), 64'd1);
    wait_idle0();

    // Reset mid-group discards the partial sum.
    send0(24'd5, 24'd5, 1'b0);
    send0(24'd6, 24'd6, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_valid", 64'(vout0), 64'd0);
    check("midrst_cnt",   64'(cnt0), 64'd0);
    check("midrst_sum",   64'(sum0), 64'd0);
    check("midrst_ready", 64'(ready0), 64'd1);
    q0.push_back(mk(64'd2, 64'd2, 64'd0));
    send0(24'd1, 24'd1, 1'b0);
    send0(24'd1, 24'd1, 1'b1);
    wait_idle0();

    // 300 beats: count saturates at 255, sum is exact, no bubbles.
    q0.push_back(mk(64'd300, 64'd255, 64'd0));
    stalls = 0;
    for (int i = 0; i < 300; i++) send0(24'd1, 24'd1, i == 299);
    check("long_group_stalls", 64'(stalls), 64'd0);
    wait_idle0();

    // Narrow instance: 5 x 225 = 1125 overflows a 9-bit accumulator.
    rdy_in1 = 1'b1;
`ifdef CMULT_MAC_SAT_EN
    q1.push_back(mk(64'd511, 64'd1, 64'd1));
`else
    q1.push_back(mk(64'd101, 64'd1, 64'd1));
`endif
    for (int i = 0; i < 5; i++) send1(4'd15, 4'd15, i == 4);
    wait_idle1();

    begin
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
        @(posedge clk); #1; n++;
      end
    end
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
